// File: rtl/input_pulse_manager_pkg.sv
// Shared types and default timing for the input pulse manager: key indices,
// repeat FSM states and a small helper for sizing frame counters.
package input_pulse_manager_pkg;

  typedef enum logic [2:0] {
    LEFT   = 3'd0,
    RIGHT  = 3'd1,
    DOWN   = 3'd2,
    ROTATE = 3'd3,
    DROP   = 3'd4
  } key_idx_t;

  localparam int unsigned NUM_KEYS = 5;
  // Only LEFT, RIGHT and DOWN auto-repeat; they occupy the low key indices.
  localparam int unsigned NUM_REP  = 3;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_DELAY,
    REP_REPEAT
  } rep_state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_DAS_FRAMES      = 10;
  localparam int unsigned DEF_ARR_FRAMES      = 3;
  localparam int unsigned DEF_ARR_DOWN_FRAMES = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: synchroniser chain, counting debouncer, armed bit and
// a one-clk press pulse on the debounced rising edge.
module btn_debounce
  import input_pulse_manager_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          deb_cnt;
  logic [CW-1:0]          rel_cnt;
  logic                   level_q;
  logic                   armed;
  logic                   synced;
  logic                   differ;
  logic                   flip;
  logic                   fall;
  logic                   rel_done;

  always_comb begin
    synced   = sync_q[SYNC_STAGES-1];
    differ   = synced ^ level;
    flip     = differ && (deb_cnt == CNT_LAST);
    fall     = flip && level;
    // A full window of confirmed-low input counts as a release, so a button
    // held through reset never arms until it is actually let go.
    rel_done = !synced && !level && (rel_cnt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      armed   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q  <= (sync_q << 1) | SYNC_STAGES'(btn);
      if (!differ || flip) deb_cnt <= '0;
      else                 deb_cnt <= deb_cnt + CW'(1);
      if (flip) level <= ~level;
      level_q <= level;
      if (synced || level)        rel_cnt <= '0;
      else if (rel_cnt != CNT_LAST) rel_cnt <= rel_cnt + CW'(1);
      if (fall || rel_done) armed <= 1'b1;
      press   <= level & ~level_q & armed;
    end
  end

endmodule

// File: rtl/input_pulse_manager.sv
// Turns five raw buttons into single-clk action pulses, with DAS/ARR
// auto-repeat on left, right and down driven by the 60Hz frame strobe.
module input_pulse_manager
  import input_pulse_manager_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DAS_FRAMES      = DEF_DAS_FRAMES,
  parameter int unsigned ARR_FRAMES      = DEF_ARR_FRAMES,
  parameter int unsigned ARR_DOWN_FRAMES = DEF_ARR_DOWN_FRAMES
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_rotate,
  input  logic btn_drop,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate,
  output logic key_drop,
  output logic key_drop_held
);

  localparam int unsigned MAX_FRAMES = max3(DAS_FRAMES, ARR_FRAMES, ARR_DOWN_FRAMES);
  localparam int unsigned FW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  logic [NUM_KEYS-1:0] btn_vec;
  logic [NUM_KEYS-1:0] lvl;
  logic [NUM_KEYS-1:0] prs;
  logic [NUM_REP-1:0]  rep_vec;
  logic                freeze;

  assign btn_vec[LEFT]   = btn_left;
  assign btn_vec[RIGHT]  = btn_right;
  assign btn_vec[DOWN]   = btn_down;
  assign btn_vec[ROTATE] = btn_rotate;
  assign btn_vec[DROP]   = btn_drop;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_vec[k]),
      .level(lvl[k]),
      .press(prs[k])
    );
  end

  // Opposing directions held together stall frame counting, but press
  // transitions still go through so either side can resume on release.
  assign freeze = lvl[LEFT] & lvl[RIGHT];

  for (genvar ch = 0; ch < NUM_REP; ch++) begin : g_rep
    localparam logic [FW-1:0] DAS_LAST = FW'(DAS_FRAMES - 1);
    localparam logic [FW-1:0] ARR_LAST = (ch == int'(DOWN)) ? FW'(ARR_DOWN_FRAMES - 1)
                                                             : FW'(ARR_FRAMES - 1);
    rep_state_t    state_q, state_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic          rep_q, rep_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rep_d   = 1'b0;
      case (state_q)
        REP_IDLE: begin
          if (prs[ch]) begin
            state_d = REP_DELAY;
            cnt_d   = '0;
          end
        end
        REP_DELAY: begin
          if (tick_game && !freeze) begin
            if (cnt_q == DAS_LAST) begin
              state_d = REP_REPEAT;
              cnt_d   = '0;
              rep_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + FW'(1);
            end
          end
        end
        REP_REPEAT: begin
          if (tick_game && !freeze) begin
            if (cnt_q == ARR_LAST) begin
              cnt_d = '0;
              rep_d = 1'b1;
            end else begin
              cnt_d = cnt_q + FW'(1);
            end
          end
        end
        default: begin
          state_d = REP_IDLE;
          cnt_d   = '0;
        end
      endcase
      if (!lvl[ch]) begin
        state_d = REP_IDLE;
        cnt_d   = '0;
        rep_d   = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= REP_IDLE;
        cnt_q   <= '0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rep_q   <= rep_d;
      end
    end

    assign rep_vec[ch] = rep_q;
  end

  assign key_left      = prs[LEFT]  | rep_vec[0];
  assign key_right     = prs[RIGHT] | rep_vec[1];
  assign key_down      = prs[DOWN]  | rep_vec[2];
  assign key_rotate    = prs[ROTATE];
  assign key_drop      = prs[DROP];
  assign key_drop_held = lvl[DROP];

endmodule

// File: tb/tb_input_pulse_manager.sv
// Scoreboard bench: directed button sequences push hand-computed output events;
// a negedge monitor pops and compares whenever the outputs show activity.
module tb_input_pulse_manager;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_game = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_rotate = 1'b0, btn_drop = 1'b0;
  logic key_left, key_right, key_down, key_rotate, key_drop, key_drop_held;

  always #5 clk = ~clk;

  input_pulse_manager #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .DAS_FRAMES     (3),
    .ARR_FRAMES     (2),
    .ARR_DOWN_FRAMES(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_game    (tick_game),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_down     (btn_down),
    .btn_rotate   (btn_rotate),
    .btn_drop     (btn_drop),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_down     (key_down),
    .key_rotate   (key_rotate),
    .key_drop     (key_drop),
    .key_drop_held(key_drop_held)
  );

  // obs = {held, left, right, down, rotate, drop}
  localparam logic [5:0] H   = 6'b100000;
  localparam logic [5:0] L   = 6'b010000;
  localparam logic [5:0] R   = 6'b001000;
  localparam logic [5:0] D   = 6'b000100;
  localparam logic [5:0] ROT = 6'b000010;
  localparam logic [5:0] DRP = 6'b000001;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  val;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          started = 1'b0;
  logic        prev_held = 1'b0;
  logic [5:0]  obs;

  assign obs = {key_drop_held, key_left, key_right, key_down, key_rotate, key_drop};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (obs[4:0] != 5'b0 || obs[5] != prev_held) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, obs);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.val !== obs) begin
            miscompares++;
            $display("FAIL event cyc=%0d got=%b want cyc=%0d val=%b", cyc, obs, e.cyc, e.val);
          end
        end
      end
      prev_held = obs[5];
    end
  end

  task automatic expect_at(input int unsigned at, input logic [5:0] val);
    sb.push_back('{at, val});
  endtask

  task automatic step(input logic l, input logic r, input logic d, input logic ro,
                      input logic dp, input logic rs, input int c);
    btn_left   = l;
    btn_right  = r;
    btn_down   = d;
    btn_rotate = ro;
    btn_drop   = dp;
    rst        = rs;
    tick_game  = (c % 10 == 9);
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (obs !== 6'b0) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b want=000000", name, cyc, obs);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
    check_zero("reset_state");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int unsigned base;
    @(negedge clk);
    do_reset();
    started = 1'b1;

    // Rotate: one pulse at +7, nothing on release, 3-clk glitch ignored.
    base = cyc;
    expect_at(base + 7, ROT);
    for (int c = 0; c < 150; c++)
      step(0, 0, 0, (c < 100) || (c >= 110 && c < 113), 0, 0, c);

    // Left held 200: press, first repeat on 3rd tick, then every 2nd tick.
    do_reset();
    base = cyc;
    expect_at(base + 7, L);
    for (int k = 0; k < 9; k++) expect_at(base + 30 + 20 * k, L);
    for (int c = 0; c < 240; c++) step(c < 200, 0, 0, 0, 0, 0, c);

    // Left+right together: both press pulses, frozen until right released.
    do_reset();
    base = cyc;
    expect_at(base + 7, L | R);
    for (int k = 0; k < 9; k++) expect_at(base + 130 + 20 * k, L);
    for (int c = 0; c < 340; c++) step(c < 300, c < 100, 0, 0, 0, 0, c);

    // Drop held through reset: level follows, no pulse until release+re-press.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 0);
    check_zero("reset_drop_held");
    base = cyc;
    expect_at(base + 6, H);
    expect_at(base + 106, 6'b0);
    expect_at(base + 146, H);
    expect_at(base + 147, H | DRP);
    expect_at(base + 206, 6'b0);
    for (int c = 0; c < 230; c++)
      step(0, 0, 0, 0, (c < 100) || (c >= 140 && c < 200), 0, c);

    // Down repeating every tick; reset lands on the edge of the next pulse.
    do_reset();
    base = cyc;
    expect_at(base + 7, D);
    expect_at(base + 30, D);
    expect_at(base + 40, D);
    expect_at(base + 50, D);
    for (int c = 0; c < 120; c++) begin
      step(0, 0, c < 90, 0, 0, (c >= 59 && c <= 62), c);
      if (c == 59) check_zero("rst_mid_repeat");
    end
    check_zero("after_down");

    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event got=none want cyc=%0d val=%b", e.cyc, e.val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_pulse_manager.md
INPUT_PULSE_MANAGER -- requirements
Module: input_pulse_manager

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser flops per button.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive clk cycles of stable synced input needed to change debounced level.
REQ-003 Parameter DAS_FRAMES, default 10: tick_game count from press pulse to first repeat (left/right/down).
REQ-004 Parameter ARR_FRAMES, default 3: tick_game count between repeats, left/right.
REQ-005 Parameter ARR_DOWN_FRAMES, default 2: tick_game count between repeats, down.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 tick_game  input  1  one-clk 60Hz frame strobe.
REQ-009 btn_left, btn_right, btn_down, btn_rotate, btn_drop  input  1 each  raw asynchronous buttons, 1 = pressed.
REQ-010 key_left, key_right, key_down, key_rotate, key_drop  output  1 each  single-clk action pulses to game control.
REQ-011 key_drop_held  output  1  debounced drop-button level, used by game control for post-lock lockout.

Function
REQ-012 Each button SHALL pass through SYNC_STAGES flops, then a debouncer whose level flips only after synced input differs from it for DEBOUNCE_CYCLES consecutive clk; any match SHALL clear the counter.
REQ-013 Press pulse SHALL assert for exactly one clk, in the cycle after debounced level rises 0->1; total latency from a clean raw rise = SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk.
REQ-014 Release SHALL produce no pulse.
REQ-015 key_rotate and key_drop SHALL emit only the press pulse; no auto-repeat.
REQ-016 Left, right, down each SHALL run a repeat FSM: REP_IDLE -> (press pulse) REP_DELAY -> (DAS_FRAMES ticks counted) REP_REPEAT; in REP_REPEAT one pulse every ARR_FRAMES (down: ARR_DOWN_FRAMES) ticks; debounced release from any state -> REP_IDLE same cycle, counter cleared.
REQ-017 Repeat pulse SHALL assert in the clk after the tick_game that completes the count; the tick completing DAS_FRAMES SHALL produce the first repeat pulse.
REQ-018 tick_game in the same cycle as the press pulse SHALL NOT be counted.
REQ-019 Frame counters SHALL be wide enough for max(DAS_FRAMES, ARR_FRAMES, ARR_DOWN_FRAMES) and SHALL never wrap; count saturates at its reload point.
REQ-020 Left and right both debounced-held: both repeat FSMs SHALL hold in their state with counters frozen, no repeat pulses; press pulses still emitted; on release of one, the other resumes counting.
REQ-021 Simultaneous press edges on several buttons SHALL each emit their own pulse in the same cycle; no prioritisation here (game control prioritises).
REQ-022 key_drop_held SHALL equal the debounced drop level, registered, independent of arming.
REQ-023 Each channel SHALL have an armed bit; a channel debounced-pressed while unarmed SHALL emit no pulse and no repeat; armed sets on debounced release.

Reset
REQ-024 On rst: all sync flops, debounced levels, debounce counters, frame counters cleared; repeat FSMs to REP_IDLE; all outputs 0.
REQ-025 On rst armed bits SHALL clear, so a button held through reset produces no pulse until released and pressed again.
REQ-026 rst mid-repeat SHALL suppress any pending repeat pulse in the following cycle.

Structure
REQ-027 Shared package (GLOBAL.sv): key index enum (LEFT, RIGHT, DOWN, ROTATE, DROP), rep_state_t, default timing constants.
REQ-028 One sub-module btn_debounce (sync + debounce + edge + armed), instantiated five times; repeat FSMs in top.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, DAS_FRAMES=3, ARR_FRAMES=2, ARR_DOWN_FRAMES=1, tick every 10 clk)
REQ-029 btn_rotate high at clk 0, held 100 clk -> key_rotate high only at clk 7; no further pulses; glitch of 3 clk -> no pulse.
REQ-030 btn_left held 200 clk -> press pulse, repeat pulse after 3rd tick, then every 2nd tick; release -> no pulse within 20 clk.
REQ-031 btn_left and btn_right pressed same clk, held 200 clk -> one key_left and one key_right pulse same cycle, zero repeats; release right -> left repeats resume.
REQ-032 btn_drop held across rst deassertion for 100 clk -> key_drop never asserts, key_drop_held goes 1 after 6 clk; release, re-press -> single key_drop pulse.
REQ-033 btn_down held, rst asserted in REP_REPEAT one clk before due pulse -> no key_down in next cycle, all outputs 0.
